// File: rtl/wb_bus_ctrl_pkg.sv
// Shared definitions for the Wishbone bus controller: FSM states, fault codes,
// default slave address map.
package wb_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_UNMAPPED = 2'd1;
    localparam logic [1:0] FAULT_SLVERR   = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

    // Default map: slot 0 = ROM, slot 1 = RAM, slot 2 = IO
    localparam logic [63:0] ROM_BASE = 64'h0000_8000_0000_0000;
    localparam logic [63:0] ROM_MASK = 64'hFFFF_FFFF_FFF0_0000;
    localparam logic [63:0] RAM_BASE = 64'h0000_0000_0000_0000;
    localparam logic [63:0] RAM_MASK = 64'hFFFF_FFFF_FFF0_0000;
    localparam logic [63:0] IO_BASE  = 64'h0000_4000_0000_0000;
    localparam logic [63:0] IO_MASK  = 64'hFFFF_FFFF_FFFF_0000;

    // Width of a slave index; at least one bit even for a single slave
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_bus_ctrl_addr_decode.sv
// Combinational address decoder: one-hot hit vector, index of the winning
// slave and a miss flag. Lowest-index matching slave wins.
module wb_addr_decode
    import wb_bus_ctrl_pkg::*;
#(
    parameter int unsigned NSLAVES   = 3,
    parameter int unsigned ADR_WIDTH = 64,
    parameter logic [NSLAVES*ADR_WIDTH-1:0] SLAVE_BASE = {IO_BASE, RAM_BASE, ROM_BASE},
    parameter logic [NSLAVES*ADR_WIDTH-1:0] SLAVE_MASK = {IO_MASK, RAM_MASK, ROM_MASK},
    localparam int unsigned IDX_W = idx_width(NSLAVES)
) (
    input  logic [ADR_WIDTH-1:0] adr_i,
    output logic [NSLAVES-1:0]   hit_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 miss_o
);

    logic found;

    // Priority match: the first matching slot claims the address
    always_comb begin
        hit_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NSLAVES; i++) begin
            if (!found &&
                ((adr_i & SLAVE_MASK[i*ADR_WIDTH +: ADR_WIDTH]) ==
                 SLAVE_BASE[i*ADR_WIDTH +: ADR_WIDTH])) begin
                found    = 1'b1;
                hit_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
        miss_o = !found;
    end

endmodule

// File: rtl/wb_bus_ctrl.sv
// Single-master Wishbone interconnect: decodes the CPU cycle onto one slave,
// registers the request, returns ack/data or err (unmapped, slave err,
// timeout) and records the last fault.
module wb_bus_ctrl
    import wb_bus_ctrl_pkg::*;
#(
    parameter int unsigned NSLAVES   = 3,
    parameter int unsigned ADR_WIDTH = 64,
    parameter int unsigned DAT_WIDTH = 64,
    parameter logic [NSLAVES*ADR_WIDTH-1:0] SLAVE_BASE = {IO_BASE, RAM_BASE, ROM_BASE},
    parameter logic [NSLAVES*ADR_WIDTH-1:0] SLAVE_MASK = {IO_MASK, RAM_MASK, ROM_MASK},
    parameter int unsigned TIMEOUT   = 16,
    localparam int unsigned SEL_WIDTH = DAT_WIDTH / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         m_cyc_i,
    input  logic                         m_stb_i,
    input  logic                         m_we_i,
    input  logic [SEL_WIDTH-1:0]         m_sel_i,
    input  logic [ADR_WIDTH-1:0]         m_adr_i,
    input  logic [DAT_WIDTH-1:0]         m_dat_i,
    output logic [DAT_WIDTH-1:0]         m_dat_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic [NSLAVES-1:0]           s_cyc_o,
    output logic [NSLAVES-1:0]           s_stb_o,
    output logic                         s_we_o,
    output logic [SEL_WIDTH-1:0]         s_sel_o,
    output logic [ADR_WIDTH-1:0]         s_adr_o,
    output logic [DAT_WIDTH-1:0]         s_dat_o,
    input  logic [NSLAVES*DAT_WIDTH-1:0] s_dat_i,
    input  logic [NSLAVES-1:0]           s_ack_i,
    input  logic [NSLAVES-1:0]           s_err_i,
    output logic                         fault_o,
    output logic [1:0]                   fault_code_o,
    output logic [ADR_WIDTH-1:0]         fault_adr_o
);

    localparam int unsigned IDX_W = idx_width(NSLAVES);
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NSLAVES-1:0]   s_cyc_q, s_cyc_d;
    logic                 s_we_q, s_we_d;
    logic [SEL_WIDTH-1:0] s_sel_q, s_sel_d;
    logic [ADR_WIDTH-1:0] s_adr_q, s_adr_d;
    logic [DAT_WIDTH-1:0] s_dat_q, s_dat_d;
    logic [DAT_WIDTH-1:0] m_dat_q, m_dat_d;
    logic                 m_ack_q, m_ack_d;
    logic                 m_err_q, m_err_d;
    logic                 fault_q, fault_d;
    logic [1:0]           fault_code_q, fault_code_d;
    logic [ADR_WIDTH-1:0] fault_adr_q, fault_adr_d;

    logic [NSLAVES-1:0]   dec_hit;
    logic [IDX_W-1:0]     dec_idx;
    logic                 dec_miss;

    wb_addr_decode #(
        .NSLAVES    (NSLAVES),
        .ADR_WIDTH  (ADR_WIDTH),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .adr_i  (m_adr_i),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx),
        .miss_o (dec_miss)
    );

    // Only the latched slave is observed while a cycle is outstanding
    logic                 sel_ack, sel_err;
    logic [DAT_WIDTH-1:0] sel_dat;
    assign sel_ack = s_ack_i[idx_q];
    assign sel_err = s_err_i[idx_q];
    assign sel_dat = s_dat_i[32'(idx_q) * DAT_WIDTH +: DAT_WIDTH];

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        s_cyc_d      = s_cyc_q;
        s_we_d       = s_we_q;
        s_sel_d      = s_sel_q;
        s_adr_d      = s_adr_q;
        s_dat_d      = s_dat_q;
        m_dat_d      = m_dat_q;
        m_ack_d      = m_ack_q;
        m_err_d      = m_err_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        fault_adr_d  = fault_adr_q;

        case (state_q)
            ST_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    s_we_d  = m_we_i;
                    s_sel_d = m_sel_i;
                    s_adr_d = m_adr_i;
                    s_dat_d = m_dat_i;
                    if (!dec_miss) begin
                        s_cyc_d = dec_hit;
                        idx_d   = dec_idx;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end else begin
                        m_err_d      = 1'b1;
                        fault_d      = 1'b1;
                        fault_code_d = FAULT_UNMAPPED;
                        fault_adr_d  = m_adr_i;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                if (!m_cyc_i) begin
                    s_cyc_d = '0;
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    if (!s_we_q) begin
                        m_dat_d = sel_dat;
                    end
                    m_ack_d = 1'b1;
                    s_cyc_d = '0;
                    state_d = ST_RESP;
                end else if (sel_err) begin
                    m_err_d      = 1'b1;
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_SLVERR;
                    fault_adr_d  = s_adr_q;
                    s_cyc_d      = '0;
                    state_d      = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    m_err_d      = 1'b1;
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_TIMEOUT;
                    fault_adr_d  = s_adr_q;
                    s_cyc_d      = '0;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                m_ack_d = 1'b0;
                m_err_d = 1'b0;
                fault_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, handshake and fault-record registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            s_cyc_q      <= '0;
            s_we_q       <= 1'b0;
            s_sel_q      <= '0;
            s_adr_q      <= '0;
            s_dat_q      <= '0;
            m_dat_q      <= '0;
            m_ack_q      <= 1'b0;
            m_err_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
            fault_adr_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            s_cyc_q      <= s_cyc_d;
            s_we_q       <= s_we_d;
            s_sel_q      <= s_sel_d;
            s_adr_q      <= s_adr_d;
            s_dat_q      <= s_dat_d;
            m_dat_q      <= m_dat_d;
            m_ack_q      <= m_ack_d;
            m_err_q      <= m_err_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            fault_adr_q  <= fault_adr_d;
        end
    end

    assign m_dat_o      = m_dat_q;
    assign m_ack_o      = m_ack_q;
    assign m_err_o      = m_err_q;
    assign s_cyc_o      = s_cyc_q;
    assign s_stb_o      = s_cyc_q;
    assign s_we_o       = s_we_q;
    assign s_sel_o      = s_sel_q;
    assign s_adr_o      = s_adr_q;
    assign s_dat_o      = s_dat_q;
    assign fault_o      = fault_q;
    assign fault_code_o = fault_code_q;
    assign fault_adr_o  = fault_adr_q;

endmodule

// File: tb/tb_wb_bus_ctrl.sv
// Directed bench for wb_bus_ctrl with a response scoreboard.
module tb_wb_bus_ctrl;

    logic         clk;
    logic         rst_i;
    logic         m_cyc_i, m_stb_i, m_we_i;
    logic [7:0]   m_sel_i;
    logic [63:0]  m_adr_i, m_dat_i, m_dat_o;
    logic         m_ack_o, m_err_o;
    logic [2:0]   s_cyc_o, s_stb_o;
    logic         s_we_o;
    logic [7:0]   s_sel_o;
    logic [63:0]  s_adr_o, s_dat_o;
    logic [191:0] s_dat_i;
    logic [2:0]   s_ack_i, s_err_i;
    logic         fault_o;
    logic [1:0]   fault_code_o;
    logic [63:0]  fault_adr_o;

    typedef struct {
        logic        err;
        logic [63:0] dat;
        logic [1:0]  code;
        logic [63:0] fadr;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          lat;
    logic [63:0] last_dat;

    wb_bus_ctrl #(
        .NSLAVES   (3),
        .ADR_WIDTH (64),
        .DAT_WIDTH (64),
        .TIMEOUT   (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .m_cyc_i      (m_cyc_i),
        .m_stb_i      (m_stb_i),
        .m_we_i       (m_we_i),
        .m_sel_i      (m_sel_i),
        .m_adr_i      (m_adr_i),
        .m_dat_i      (m_dat_i),
        .m_dat_o      (m_dat_o),
        .m_ack_o      (m_ack_o),
        .m_err_o      (m_err_o),
        .s_cyc_o      (s_cyc_o),
        .s_stb_o      (s_stb_o),
        .s_we_o       (s_we_o),
        .s_sel_o      (s_sel_o),
        .s_adr_o      (s_adr_o),
        .s_dat_o      (s_dat_o),
        .s_dat_i      (s_dat_i),
        .s_ack_i      (s_ack_i),
        .s_err_i      (s_err_i),
        .fault_o      (fault_o),
        .fault_code_o (fault_code_o),
        .fault_adr_o  (fault_adr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence itself hangs
    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request; returns just after the edge that samples it
    task automatic issue(input logic [63:0] adr, input logic we,
                         input logic [7:0] sel, input logic [63:0] dat);
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = we;
        m_sel_i = sel;
        m_adr_i = adr;
        m_dat_i = dat;
        step();
    endtask

    // Wait for ack/err, check it against the scoreboard, release the bus
    task automatic wait_resp(input string tag, input int budget, output int cyc);
        exp_t e;
        cyc = 0;
        while (!(m_ack_o || m_err_o) && cyc < budget) begin
            step();
            cyc++;
        end
        chk({tag, "_seen"}, 64'(m_ack_o | m_err_o), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_ack"},   64'(m_ack_o), 64'(!e.err));
            chk({tag, "_err"},   64'(m_err_o), 64'(e.err));
            chk({tag, "_fault"}, 64'(fault_o), 64'(e.err));
            chk({tag, "_dat"},   m_dat_o, e.dat);
            chk({tag, "_code"},  64'(fault_code_o), 64'(e.code));
            chk({tag, "_fadr"},  fault_adr_o, e.fadr);
        end
        chk({tag, "_scyc_off"}, 64'(s_cyc_o), 64'd0);
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_ack_i = '0;
        s_err_i = '0;
        step();
        chk({tag, "_ack_pulse"},   64'(m_ack_o), 64'd0);
        chk({tag, "_err_pulse"},   64'(m_err_o), 64'd0);
        chk({tag, "_fault_pulse"}, 64'(fault_o), 64'd0);
    endtask

    initial begin
        rst_i   = 1'b1;
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        m_we_i  = 1'b0;
        m_sel_i = '0;
        m_adr_i = '0;
        m_dat_i = '0;
        s_dat_i = '0;
        s_ack_i = '0;
        s_err_i = '0;
        last_dat = '0;
        repeat (3) step();

        // Reset state
        chk("rst_ack",   64'(m_ack_o), 64'd0);
        chk("rst_err",   64'(m_err_o), 64'd0);
        chk("rst_mdat",  m_dat_o, 64'd0);
        chk("rst_scyc",  64'(s_cyc_o), 64'd0);
        chk("rst_sstb",  64'(s_stb_o), 64'd0);
        chk("rst_swe",   64'(s_we_o), 64'd0);
        chk("rst_sadr",  s_adr_o, 64'd0);
        chk("rst_fault", 64'(fault_o), 64'd0);
        chk("rst_code",  64'(fault_code_o), 64'd0);
        rst_i = 1'b0;
        step();

        // Unmapped read: err visible right after the sampling edge
        issue(64'h0000_1234_0000_0000, 1'b0, 8'hFF, 64'd0);
        sb.push_back('{err: 1'b1, dat: last_dat, code: 2'd1, fadr: 64'h0000_1234_0000_0000});
        chk("unm_scyc", 64'(s_cyc_o), 64'd0);
        chk("unm_sstb", 64'(s_stb_o), 64'd0);
        wait_resp("unmapped", 4, lat);
        chk("unm_lat", 64'(lat), 64'd0);

        // Reset held 3 cycles in the middle of an IO cycle
        issue(64'h0000_4000_0000_0010, 1'b0, 8'hFF, 64'd0);
        chk("midrst_scyc_before", 64'(s_cyc_o), 64'b100);
        repeat (2) step();
        rst_i   = 1'b1;
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        repeat (3) step();
        chk("midrst_scyc", 64'(s_cyc_o), 64'd0);
        chk("midrst_sadr", s_adr_o, 64'd0);
        chk("midrst_err",  64'(m_err_o), 64'd0);
        chk("midrst_code", 64'(fault_code_o), 64'd0);
        chk("midrst_fadr", fault_adr_o, 64'd0);
        rst_i = 1'b0;
        step();

        // ROM read, zero-wait slave
        issue(64'h0000_8000_0000_0008, 1'b0, 8'hFF, 64'd0);
        chk("rom_scyc", 64'(s_cyc_o), 64'b001);
        chk("rom_sstb", 64'(s_stb_o), 64'b001);
        chk("rom_swe",  64'(s_we_o), 64'd0);
        chk("rom_sadr", s_adr_o, 64'h0000_8000_0000_0008);
        s_ack_i = 3'b001;
        s_dat_i[0 +: 64] = 64'hDEAD_BEEF_0123_4567;
        last_dat = 64'hDEAD_BEEF_0123_4567;
        sb.push_back('{err: 1'b0, dat: last_dat, code: 2'd0, fadr: 64'd0});
        wait_resp("rom_rd", 8, lat);
        chk("rom_lat", 64'(lat), 64'd1);

        // RAM write; master inputs change mid-cycle and must not be re-sampled
        issue(64'h10, 1'b1, 8'hFF, 64'hA5A5);
        chk("wr_scyc", 64'(s_cyc_o), 64'b010);
        chk("wr_swe",  64'(s_we_o), 64'd1);
        chk("wr_sdat", s_dat_o, 64'hA5A5);
        chk("wr_ssel", 64'(s_sel_o), 64'hFF);
        m_dat_i = 64'hFFFF;
        m_adr_i = 64'h20;
        step();
        chk("wr_sdat_hold", s_dat_o, 64'hA5A5);
        chk("wr_sadr_hold", s_adr_o, 64'h10);
        s_ack_i = 3'b010;
        s_dat_i[64 +: 64] = 64'h5555_5555_5555_5555;
        sb.push_back('{err: 1'b0, dat: last_dat, code: 2'd0, fadr: 64'd0});
        wait_resp("ram_wr", 8, lat);
        chk("wr_lat", 64'(lat), 64'd1);

        // Slave err on RAM while an unselected slave acks
        issue(64'h40, 1'b0, 8'h0F, 64'd0);
        s_err_i = 3'b010;
        s_ack_i = 3'b001;
        sb.push_back('{err: 1'b1, dat: last_dat, code: 2'd2, fadr: 64'h40});
        wait_resp("slverr", 8, lat);
        chk("slverr_lat", 64'(lat), 64'd1);

        // IO never responds: timeout after 16 busy cycles
        issue(64'h0000_4000_0000_0100, 1'b0, 8'hFF, 64'd0);
        sb.push_back('{err: 1'b1, dat: last_dat, code: 2'd3, fadr: 64'h0000_4000_0000_0100});
        wait_resp("timeout", 40, lat);
        chk("timeout_lat", 64'(lat), 64'd16);

        // Ack on the expiry cycle wins over the timeout
        issue(64'h0000_4000_0000_0200, 1'b0, 8'hFF, 64'd0);
        repeat (15) step();
        chk("tmo_edge_scyc", 64'(s_cyc_o), 64'b100);
        chk("tmo_edge_err",  64'(m_err_o), 64'd0);
        s_ack_i = 3'b100;
        s_dat_i[128 +: 64] = 64'h0123_4567_89AB_CDEF;
        last_dat = 64'h0123_4567_89AB_CDEF;
        sb.push_back('{err: 1'b0, dat: last_dat, code: 2'd3, fadr: 64'h0000_4000_0000_0100});
        wait_resp("tmo_ack", 4, lat);
        chk("tmo_ack_lat", 64'(lat), 64'd1);

        // Master abort in BUSY, then a late slave ack
        issue(64'h20, 1'b0, 8'hFF, 64'd0);
        step();
        chk("abort_scyc_before", 64'(s_cyc_o), 64'b010);
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        step();
        chk("abort_scyc", 64'(s_cyc_o), 64'd0);
        chk("abort_sstb", 64'(s_stb_o), 64'd0);
        chk("abort_ack",  64'(m_ack_o), 64'd0);
        chk("abort_err",  64'(m_err_o), 64'd0);
        s_ack_i = 3'b010;
        s_dat_i[64 +: 64] = 64'h0BAD_0BAD_0BAD_0BAD;
        repeat (2) step();
        chk("late_ack",   64'(m_ack_o), 64'd0);
        chk("late_err",   64'(m_err_o), 64'd0);
        chk("late_mdat",  m_dat_o, last_dat);
        chk("late_fault", 64'(fault_o), 64'd0);
        s_ack_i = '0;
        step();

        // Controller still serves requests after the abort
        issue(64'h0000_8000_0000_0100, 1'b0, 8'hFF, 64'd0);
        chk("post_scyc", 64'(s_cyc_o), 64'b001);
        s_ack_i = 3'b001;
        s_dat_i[0 +: 64] = 64'h1111_2222_3333_4444;
        last_dat = 64'h1111_2222_3333_4444;
        sb.push_back('{err: 1'b0, dat: last_dat, code: 2'd3, fadr: 64'h0000_4000_0000_0100});
        wait_resp("post_rd", 8, lat);
        chk("post_lat", 64'(lat), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
